// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tags
// and the width of the read-latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch (I) and load/store (D).
// MEM_ARB_RR_EN selects round-robin on ties; otherwise D always beats I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t rr_last,
  output arb_owner_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_D;
    if (i_req && d_req) begin
      winner = (rr_last == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end
`else
  logic unusedRrLast;
  assign unusedRrLast = (rr_last == OWN_D);

  always_comb begin
    winner = OWN_D;
    if (i_req && !d_req) begin
      winner = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle core: one I/D transaction at
// a time, fixed read latency, one-cycle done pulse. MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state;
  arb_owner_t        owner;
  arb_owner_t        winner;
  arb_owner_t        rrLast;
  logic              weQ;
  logic [LAT_W-1:0]  cnt;
  logic              grant;
  logic [ADDR_W-1:0] selAddr;

  mem_arb_pick uPick (
    .i_req  (i_req),
    .d_req  (d_req),
    .rr_last(rrLast),
    .winner (winner)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrLast <= OWN_D;
    end else if (grant) begin
      rrLast <= winner;
    end
  end
`else
  assign rrLast = OWN_D;
`endif

  assign i_gnt   = i_req & (winner == OWN_I) & (state == IDLE);
  assign d_gnt   = d_req & (winner == OWN_D) & (state == IDLE);
  assign grant   = i_gnt | d_gnt;
  assign selAddr = (winner == OWN_D) ? d_addr : i_addr;
  assign busy    = (state != IDLE);

  // mem_addr/mem_wdata double as the captured request; done/err/mem_en are
  // registered on entry to the state in which they are visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_D;
      weQ       <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner     <= winner;
            mem_addr  <= selAddr;
            weQ       <= (winner == OWN_D) & d_we;
            mem_wdata <= (winner == OWN_D) ? d_wdata : '0;
            if (selAddr[1:0] != 2'b00) begin
              state <= RESP;
              if (winner == OWN_D) begin
                d_done <= 1'b1;
                d_err  <= 1'b1;
              end else begin
                i_done <= 1'b1;
                i_err  <= 1'b1;
              end
            end else begin
              state  <= ACCESS;
              mem_en <= 1'b1;
              mem_we <= (winner == OWN_D) & d_we;
            end
          end
        end
        ACCESS: begin
          if (weQ) begin
            state  <= RESP;
            d_done <= 1'b1;
          end else begin
            cnt   <= LAT_W'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner == OWN_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: two instances with read
// latency 1 and 4, each fed by a delayed-read memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        iReq     [2];
  logic [31:0] iAddr    [2];
  logic        iGnt     [2];
  logic        iDone    [2];
  logic        iErr     [2];
  logic [31:0] iRdata   [2];
  logic        dReq     [2];
  logic        dWe      [2];
  logic [31:0] dAddr    [2];
  logic [31:0] dWdata   [2];
  logic        dGnt     [2];
  logic        dDone    [2];
  logic        dErr     [2];
  logic [31:0] dRdata   [2];
  logic        memEn    [2];
  logic        memWe    [2];
  logic [31:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];
  logic        busy     [2];

  logic [31:0] memWord  [2];
  logic [15:0] pv       [2];
  logic [31:0] pd       [2][16];

  logic [31:0] expIR    [2];
  logic [31:0] expDR    [2];
  bit          rrD      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[0]),
    .i_req(iReq[0]), .i_addr(iAddr[0]), .i_gnt(iGnt[0]), .i_done(iDone[0]),
    .i_err(iErr[0]), .i_rdata(iRdata[0]),
    .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
    .d_gnt(dGnt[0]), .d_done(dDone[0]), .d_err(dErr[0]), .d_rdata(dRdata[0]),
    .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst[1]),
    .i_req(iReq[1]), .i_addr(iAddr[1]), .i_gnt(iGnt[1]), .i_done(iDone[1]),
    .i_err(iErr[1]), .i_rdata(iRdata[1]),
    .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
    .d_gnt(dGnt[1]), .d_done(dDone[1]), .d_err(dErr[1]), .d_rdata(dRdata[1]),
    .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]), .busy(busy[1])
  );

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Read data is valid exactly latOf(k) cycles after mem_en, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) pv[k] <= '0;
      else        pv[k] <= {pv[k][14:0], memEn[k]};
      pd[k][0] <= memWord[k];
      for (int j = 1; j < 16; j++) pd[k][j] <= pd[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      memRdata[k] = pv[k][latOf(k)-1] ? pd[k][latOf(k)-1] : 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] allOut(input int k);
    return {22'd0, busy[k], iGnt[k], iDone[k], iErr[k], dGnt[k], dDone[k],
            dErr[k], memEn[k], memWe[k],
            |{iRdata[k], dRdata[k], memAddr[k], memWdata[k]}};
  endfunction

  // One transaction starting in the next cycle; checks grant, mem strobe and
  // done timing cycle by cycle, then err and both rdata registers at done.
  task automatic xact(input int k, input bit isD, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] word, input bit coI,
                      input logic [31:0] coAddr, input string tag);
    int  doneAt;
    bit  mis;
    bit  ownG, othG, ownDn, ownEr;
    mis    = (addr[1:0] != 2'b00);
    doneAt = mis ? 1 : ((isD && we) ? 2 : 2 + latOf(k));
    memWord[k] = word;
    tick();
    if (isD) begin
      dReq[k] = 1'b1; dWe[k] = we; dAddr[k] = addr; dWdata[k] = wdata;
      if (coI) begin
        iReq[k] = 1'b1; iAddr[k] = coAddr;
      end
    end else begin
      iReq[k] = 1'b1; iAddr[k] = addr;
    end
    settle();
    ownG = isD ? dGnt[k] : iGnt[k];
    othG = isD ? iGnt[k] : dGnt[k];
    chk({tag, "_gnt"}, 32'({ownG, othG, busy[k]}), 32'({1'b1, 1'b0, 1'b0}));
    rrD[k] = isD;
    for (int c = 1; c <= doneAt; c++) begin
      tick();
      if (isD) dReq[k] = 1'b0; else iReq[k] = 1'b0;
      settle();
      othG  = isD ? iGnt[k] : dGnt[k];
      ownDn = isD ? dDone[k] : iDone[k];
      chk({tag, "_en_done"}, 32'({memEn[k], ownDn, othG, busy[k]}),
          32'({(!mis && c == 1), (c == doneAt), 1'b0, 1'b1}));
      if (!mis && c == 1) begin
        chk({tag, "_mem_we"}, 32'(memWe[k]), 32'(isD && we));
        chk({tag, "_mem_addr"}, memAddr[k], addr);
        if (isD && we) chk({tag, "_mem_wdata"}, memWdata[k], wdata);
      end
    end
    ownEr = isD ? dErr[k] : iErr[k];
    chk({tag, "_err"}, 32'(ownEr), 32'(mis));
    if (!mis && !(isD && we)) begin
      if (isD) expDR[k] = word; else expIR[k] = word;
    end
    chk({tag, "_i_rdata"}, iRdata[k], expIR[k]);
    chk({tag, "_d_rdata"}, dRdata[k], expDR[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int  doneCnt;
    int  waited;
    bit  expD;
    bit  got;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; iReq[k] = 1'b0; iAddr[k] = '0; dReq[k] = 1'b0;
      dWe[k] = 1'b0; dAddr[k] = '0; dWdata[k] = '0; memWord[k] = '0;
      expIR[k] = '0; expDR[k] = '0; rrD[k] = 1'b1;
    end
    tick();
    tick();
    chk("reset_outs0", allOut(0), 32'd0);
    chk("reset_outs1", allOut(1), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    xact(0, 1'b0, 1'b0, 32'h10, '0, 32'h00A0_0093, 1'b0, '0, "fetch");
    xact(0, 1'b1, 1'b0, 32'h200, '0, 32'h1111_2222, 1'b1, 32'h20, "tie_d");
    xact(0, 1'b0, 1'b0, 32'h20, '0, 32'h3333_4444, 1'b0, '0, "tie_i");
    xact(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h5555_6666, 1'b0, '0, "store");
    xact(0, 1'b1, 1'b0, 32'h102, '0, 32'h7777_8888, 1'b0, '0, "misalign");
    xact(0, 1'b0, 1'b0, 32'h41, '0, 32'h9999_AAAA, 1'b0, '0, "imisalign");

    xact(1, 1'b1, 1'b0, 32'h80, '0, 32'h1234_5678, 1'b0, '0, "lat4_load");

    // Reset while DUT4 is in WAIT: everything clears, no done follows.
    memWord[1] = 32'hFACE_0001;
    tick();
    iReq[1] = 1'b1; iAddr[1] = 32'h40;
    settle();
    chk("rw_gnt", 32'(iGnt[1]), 32'd1);
    tick();
    iReq[1] = 1'b0;
    tick();
    tick();
    rst[1] = 1'b1;
    settle();
    chk("rw_outs", allOut(1), 32'd0);
    doneCnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 1) rst[1] = 1'b0;
      settle();
      if (iDone[1] || dDone[1]) doneCnt++;
    end
    chk("rw_no_done", 32'(doneCnt), 32'd0);
    chk("rw_idle", 32'(busy[1]), 32'd0);
    expIR[1] = '0; expDR[1] = '0; rrD[1] = 1'b1;
    xact(1, 1'b0, 1'b0, 32'h44, '0, 32'hCAFE_F00D, 1'b0, '0, "rw_fetch");

    // Both requesters held high for four grants.
    memWord[0] = 32'h0BAD_F00D;
    tick();
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h300;
    iReq[0] = 1'b1; iAddr[0] = 32'h30;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      waited = 0;
      while (!got && waited < 20) begin
        settle();
        if (iGnt[0] || dGnt[0]) begin
          got  = 1'b1;
          expD = RR ? !rrD[0] : 1'b1;
          chk("cont_owner", 32'({dGnt[0], iGnt[0]}), 32'({expD, !expD}));
          rrD[0] = dGnt[0];
        end
        tick();
        waited++;
      end
      if (!got) chk("cont_timeout", 32'd0, 32'd1);
    end
    dReq[0] = 1'b0;
    iReq[0] = 1'b0;
    waited = 0;
    while (busy[0] && waited < 20) begin
      tick();
      waited++;
    end
    settle();
    chk("cont_drain", 32'(busy[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
